// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SEC-DED codec.
//   calc_p   : number of Hamming parity bits needed for a given data width
//   data_pos : 1-based Hamming position that carries data bit i
//   codec_mode_e : per-beat operating mode
package hamming_pkg;

  typedef enum logic {
    ENCODE = 1'b0,
    DECODE = 1'b1
  } codec_mode_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned calc_p(input int unsigned data_w);
    int unsigned p;
    p = 0;
    for (int unsigned k = 1; k <= 7; k++) begin
      if (p == 0 && (32'd1 << k) >= data_w + k + 1) p = k;
    end
    return p;
  endfunction

  // Data bits fill the non-power-of-two positions 3, 5, 6, 7, 9, ... LSB first.
  function automatic int unsigned data_pos(input int unsigned i);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned q = 3; q < 64; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == i && pos == 0) pos = q;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/module_hamming_syndrome.sv
// Combinational syndrome / overall-parity generator.
//   word : CODE_W-bit word, Hamming positions 1..DATA_W+P at bits [DATA_W+P-1:0]
//   syn  : XOR of the Hamming indices of all set bits in positions 1..DATA_W+P
//   par  : XOR of all CODE_W bits
module module_hamming_syndrome #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned P      = 3,
  parameter int unsigned CODE_W = 8
) (
  input  logic [CODE_W-1:0] word,
  output logic [P-1:0]      syn,
  output logic              par
);

  always_comb begin
    syn = '0;
    for (int unsigned pos = 1; pos <= DATA_W + P; pos++) begin
      if (word[pos-1]) syn = syn ^ P'(pos);
    end
  end

  assign par = ^word;

endmodule

// File: rtl/module_hamming_secded.sv
// Parametrised Hamming SEC-DED encoder/decoder, 2-stage valid/ready pipeline.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready/in_mode/in_data    : input beat (mode 0 encode, 1 decode)
//   out_valid/out_ready/out_data         : output beat (codeword or corrected data)
//   out_syndrome/out_err_single/out_err_double : decode status, 0 when encoding
//   clr_cnt, cnt_single, cnt_double      : saturating counters of delivered error beats
module module_hamming_secded
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned P      = calc_p(DATA_W),
  localparam int unsigned CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  localparam int unsigned NPOS = DATA_W + P;

  logic              s1_valid_q;
  codec_mode_e       s1_mode_q;
  logic [CODE_W-1:0] s1_word_q;
  logic [P-1:0]      s1_syn_q;
  logic              s1_par_q;

  logic              s2_valid_q;
  logic [CODE_W-1:0] s2_data_q;
  logic [P-1:0]      s2_syn_q;
  logic              s2_single_q;
  logic              s2_double_q;

  logic [CNT_W-1:0]  cnt_single_q;
  logic [CNT_W-1:0]  cnt_double_q;

  logic s1_en;
  logic s2_en;
  logic out_hs;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && rst_n;
  assign out_hs   = s2_valid_q && out_ready;

  // Encode: place data in its Hamming positions with parity slots left at zero, so the
  // syndrome of that word is exactly the parity bit vector.
  logic [CODE_W-1:0] scatter;
  logic [CODE_W-1:0] syn_word;
  logic [P-1:0]      syn;
  logic              par;

  always_comb begin
    scatter = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      scatter[data_pos(i)-1] = in_data[i];
    end
  end

  assign syn_word = in_mode ? in_data : scatter;

  module_hamming_syndrome #(
    .DATA_W(DATA_W),
    .P     (P),
    .CODE_W(CODE_W)
  ) u_syndrome (
    .word(syn_word),
    .syn (syn),
    .par (par)
  );

  // Stage-2 result: finished codeword or corrected/extracted data plus flags.
  logic [CODE_W-1:0] enc_word;
  logic [CODE_W-1:0] fix_word;
  logic [DATA_W-1:0] dec_data;
  logic              in_range;
  logic              single_d;
  logic              double_d;
  logic [CODE_W-1:0] s2_data_d;
  logic [P-1:0]      s2_syn_d;

  always_comb begin
    enc_word = s1_word_q;
    for (int unsigned k = 0; k < P; k++) begin
      enc_word[(1 << k) - 1] = s1_syn_q[k];
    end
    enc_word[CODE_W-1] = ^enc_word[CODE_W-2:0];

    // S=0 with G=1 is an error in the overall-parity bit itself: counted, nothing to flip.
    in_range = (32'(s1_syn_q) <= NPOS);
    single_d = s1_par_q && in_range;
    double_d = (s1_par_q && !in_range) || (!s1_par_q && (s1_syn_q != '0));

    fix_word = s1_word_q;
    for (int unsigned pos = 1; pos <= NPOS; pos++) begin
      if (single_d && (s1_syn_q == P'(pos))) fix_word[pos-1] = ~fix_word[pos-1];
    end

    dec_data = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      dec_data[i] = fix_word[data_pos(i)-1];
    end

    if (s1_mode_q == DECODE) begin
      s2_data_d = CODE_W'(dec_data);
      s2_syn_d  = s1_syn_q;
    end else begin
      s2_data_d = enc_word;
      s2_syn_d  = '0;
      single_d  = 1'b0;
      double_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= ENCODE;
      s1_word_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_syn_q    <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mode_q <= codec_mode_e'(in_mode);
          s1_word_q <= syn_word;
          s1_syn_q  <= syn;
          s1_par_q  <= par;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q   <= s2_data_d;
          s2_syn_q    <= s2_syn_d;
          s2_single_q <= single_d;
          s2_double_q <= double_d;
        end
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      if (out_hs && s2_single_q && (cnt_single_q != '1)) begin
        cnt_single_q <= cnt_single_q + CNT_W'(1);
      end
      if (out_hs && s2_double_q && (cnt_double_q != '1)) begin
        cnt_double_q <= cnt_double_q + CNT_W'(1);
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = s2_data_q;
  assign out_syndrome   = s2_syn_q;
  assign out_err_single = s2_single_q;
  assign out_err_double = s2_double_q;
  assign cnt_single     = cnt_single_q;
  assign cnt_double     = cnt_double_q;

endmodule

// File: doc/module_hamming_secded.md
# module_hamming_secded

Parametrised Hamming SEC-DED codec with a streaming valid/ready interface. It extends the fixed 7-bit Hamming(7,4) encoder to any data width and adds an overall-parity bit. It adds a decode mode that corrects single errors and flags double errors, and keeps saturating error counters. It sits between the data source and the transmission/display path, with a 2-stage pipeline and full back-pressure.

## Interface
- DATA_W, default 4: data bits per word, legal range 4..32.
- P, derived (localparam): smallest P with 2^P >= DATA_W+P+1; equals 3 for DATA_W=4.
- CODE_W, derived (localparam): DATA_W+P+1; equals 8 for DATA_W=4.
- CNT_W, default 16: error counter width.
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  1  0 = encode, 1 = decode; sampled with the beat.
- in_data  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_syndrome  out  P  decode syndrome; 0 in encode mode.
- out_err_single  out  1  single error detected and corrected (decode only).
- out_err_double  out  1  uncorrectable error (decode only).
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  saturating count of delivered single-error beats.
- cnt_double  out  CNT_W  saturating count of delivered double-error beats.

## Operation
- Codeword layout:
  - Hamming positions 1..DATA_W+P map to code bit index pos-1.
  - Powers of two are parity positions; the remaining positions take data LSB-first.
  - Bit CODE_W-1 is overall parity: XOR of bits [CODE_W-2:0], giving even parity over the word.
  - For DATA_W=4, bits [6:0] equal the existing (7,4) layout: d0@2, d1@4, d2@5, d3@6, c0@0, c1@1, c2@3.
- Encode: parity bit k = XOR of data positions whose index has bit k set. out_syndrome, out_err_single and out_err_double are 0.
- Decode: S = XOR of indices of all set bits in positions 1..DATA_W+P; G = XOR of all CODE_W bits.
  - S=0, G=0: clean, no flags.
  - G=1, S=0: overall-parity bit error; data unchanged; err_single=1.
  - G=1, 0<S<=DATA_W+P: flip position S, extract data; err_single=1.
  - G=1, S>DATA_W+P: err_double=1; data extracted uncorrected.
  - G=0, S!=0: err_double=1; data extracted uncorrected.
- Counters:
  - Increment only on an output handshake (out_valid && out_ready) of a beat whose flag is set.
  - Saturate at all-ones.
  - When clr_cnt coincides with an increment, the clear wins and the counter reads 0 next cycle.

## Timing
- Pipeline: stage 1 registers the input beat, S and G; stage 2 registers the corrected/encoded result and flags.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput is 1 beat/cycle.
- Stall logic:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en && rst_n (combinational)
- Once out_valid is asserted, out_data and the flags stay stable until the handshake. Beats are never dropped or reordered.
- Reset: while rst_n=0, in_ready=0. On the first edge with rst_n=0, all valids, data, syndrome, flags and counters clear to 0. A reset mid-stream discards in-flight beats.
- Mode may change on every beat; each beat carries its own mode through the pipe.

## Structure
- Package hamming_pkg:
  - function calc_p(DATA_W) giving P;
  - function data_pos(i) giving the Hamming position of data bit i;
  - typedef enum codec_mode_e {ENCODE=0, DECODE=1}.
- One sub-module: module_hamming_syndrome, a combinational generator of S and G over a CODE_W word.
  - Encode reuses it with the parity positions zeroed; S then equals the parity bits.
  - Decode uses it directly.
- The top holds the pipeline registers, correction mux and counters.

## Test plan
- Encode DATA_W=4, in_data=4'hB -> after 2 cycles out_data=8'h55, flags 0, syndrome 0.
- Decode 8'h55 -> out_data=4'hB, no flags. Decode 8'h45 (bit 4 flipped) -> syndrome 5, err_single=1, data 4'hB, cnt_single=1.
- Decode 8'hD5 -> syndrome 0, err_single=1, data 4'hB. Decode 8'h56 -> err_double=1, data 4'hB, cnt_double=1.
- Back-pressure: out_ready=0 for 5 cycles while 3 beats are offered -> exactly 2 accepted, in_ready=0 thereafter. Release gives ordered delivery, one beat per cycle.
- Counters: 2^CNT_W+1 single-error beats -> cnt_single holds all-ones. clr_cnt together with an error handshake -> 0. rst_n low mid-stream -> out_valid=0 and counters 0 next cycle.
- DATA_W=8, random data and random 0/1/2-bit corruptions, 10k beats -> data matches when ≤1 error, err_double set for every 2-bit error.
